// File: rtl/top_entity_pkg.sv
// rtl/top_entity_pkg.sv - shared constants, types and stream indices for top_entity
package top_entity_pkg;

  typedef logic signed [63:0] int64_t;

  localparam int     NUM_STAGES_DEF = 5;
  localparam int64_t CMP_CONST_DEF  = 64'sd5;

  // Bit positions of the per-stream enable/aktv vectors; the 1-bit streams
  // come first so they can be handled with a single loop.
  typedef enum logic [2:0] {
    STR_LT       = 3'd0,
    STR_GT       = 3'd1,
    STR_NEQ      = 3'd2,
    STR_NOT_A    = 3'd3,
    STR_A_IMPL_B = 3'd4,
    STR_TIME     = 3'd5
  } stream_idx_e;

  localparam int NUM_STREAMS      = 6;
  localparam int NUM_BOOL_STREAMS = 5;

endpackage

// File: rtl/llc_stage_counter.sv
// rtl/llc_stage_counter.sv - LLC stage counter and enabled-cycle counter
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              advance both counters when 1, hold otherwise
//   llc_stage       0..NUM_STAGES-1, wraps
//   hlc_clock_cnt   number of enabled cycles since reset (wraps at 2^64)
module llc_stage_counter
  import top_entity_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output int64_t llc_stage,
  output int64_t hlc_clock_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      llc_stage     <= '0;
      hlc_clock_cnt <= '0;
    end else if (en) begin
      if (llc_stage == int64_t'(NUM_STAGES - 1)) llc_stage <= '0;
      else                                       llc_stage <= llc_stage + 64'sd1;
      hlc_clock_cnt <= hlc_clock_cnt + 64'sd1;
    end
  end

endmodule

// File: rtl/top_entity.sv
// rtl/top_entity.sv - HLC event acceptance and two-stage stream evaluation
// Ports:
//   clk, rst, en                      clock, async active-high reset, global enable
//   input_{a,b,id}, new_input_*       input values and their new-value flags
//   hlc_clock, hlc_clock_cnt          event pulse, enabled-cycle count
//   hlc_a, hlc_b, hlc_id              latched input values
//   hlc_en_*                          per-stream enables, valid with hlc_clock
//   llc_stage                         current LLC stage
//   output_*, output_*_aktv           stream values and one-cycle valid pulses
module top_entity
  import top_entity_pkg::*;
#(
  parameter int     NUM_STAGES = NUM_STAGES_DEF,
  parameter int64_t CMP_CONST  = CMP_CONST_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   input_a,
  input  logic   new_input_a,
  input  logic   input_b,
  input  logic   new_input_b,
  input  int64_t input_id,
  input  logic   new_input_id,
  output logic   hlc_clock,
  output int64_t hlc_clock_cnt,
  output logic   hlc_a,
  output logic   hlc_b,
  output int64_t hlc_id,
  output logic   hlc_en_lt,
  output logic   hlc_en_gt,
  output logic   hlc_en_neq,
  output logic   hlc_en_not_a,
  output logic   hlc_en_a_impl_b,
  output logic   hlc_en_time_stream,
  output int64_t llc_stage,
  output logic   output_lt,
  output logic   output_lt_aktv,
  output logic   output_gt,
  output logic   output_gt_aktv,
  output logic   output_neq,
  output logic   output_neq_aktv,
  output logic   output_not_a,
  output logic   output_not_a_aktv,
  output logic   output_a_impl_b,
  output logic   output_a_impl_b_aktv,
  output int64_t output_time_stream,
  output logic   output_time_stream_aktv
);

  logic                        any_new;
  logic                        accept;
  logic [NUM_STREAMS-1:0]      en_next;
  logic [NUM_STREAMS-1:0]      hlc_en;
  logic [NUM_STREAMS-1:0]      aktv_q;
  logic [NUM_BOOL_STREAMS-1:0] str_val;
  logic [NUM_BOOL_STREAMS-1:0] out_q;
  int64_t                      out_time;

  llc_stage_counter #(.NUM_STAGES(NUM_STAGES)) u_counter (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .llc_stage    (llc_stage),
    .hlc_clock_cnt(hlc_clock_cnt)
  );

  always_comb begin
    any_new               = new_input_a | new_input_b | new_input_id;
    accept                = en && (llc_stage == '0) && any_new;
    en_next               = '0;
    en_next[STR_LT]       = new_input_id;
    en_next[STR_GT]       = new_input_id;
    en_next[STR_NEQ]      = new_input_a & new_input_b;
    en_next[STR_NOT_A]    = new_input_a;
    en_next[STR_A_IMPL_B] = new_input_a & new_input_b;
    en_next[STR_TIME]     = any_new;
  end

  // Stream values are computed from the latched inputs, so they are valid
  // on the edge after acceptance.
  always_comb begin
    str_val               = '0;
    str_val[STR_LT]       = hlc_id < CMP_CONST;
    str_val[STR_GT]       = hlc_id > CMP_CONST;
    str_val[STR_NEQ]      = hlc_a != hlc_b;
    str_val[STR_NOT_A]    = ~hlc_a;
    str_val[STR_A_IMPL_B] = ~hlc_a | hlc_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hlc_clock <= 1'b0;
      hlc_en    <= '0;
      hlc_a     <= 1'b0;
      hlc_b     <= 1'b0;
      hlc_id    <= '0;
      out_q     <= '0;
      out_time  <= '0;
      aktv_q    <= '0;
    end else if (en) begin
      if (accept) begin
        hlc_clock <= 1'b1;
        hlc_en    <= en_next;
        if (new_input_a)  hlc_a  <= input_a;
        if (new_input_b)  hlc_b  <= input_b;
        if (new_input_id) hlc_id <= input_id;
      end else begin
        hlc_clock <= 1'b0;
        hlc_en    <= '0;
      end

      if (hlc_clock) begin
        for (int i = 0; i < NUM_BOOL_STREAMS; i++) begin
          if (hlc_en[i]) out_q[i] <= str_val[i];
        end
        // The counter has advanced exactly once since acceptance (it freezes
        // with en), so the pre-increment sample is the current value minus one.
        if (hlc_en[STR_TIME]) out_time <= hlc_clock_cnt - 64'sd1;
        aktv_q <= hlc_en;
      end else begin
        aktv_q <= '0;
      end
    end
  end

  assign hlc_en_lt               = hlc_en[STR_LT];
  assign hlc_en_gt               = hlc_en[STR_GT];
  assign hlc_en_neq              = hlc_en[STR_NEQ];
  assign hlc_en_not_a            = hlc_en[STR_NOT_A];
  assign hlc_en_a_impl_b         = hlc_en[STR_A_IMPL_B];
  assign hlc_en_time_stream      = hlc_en[STR_TIME];

  assign output_lt               = out_q[STR_LT];
  assign output_gt               = out_q[STR_GT];
  assign output_neq              = out_q[STR_NEQ];
  assign output_not_a            = out_q[STR_NOT_A];
  assign output_a_impl_b         = out_q[STR_A_IMPL_B];
  assign output_time_stream      = out_time;

  assign output_lt_aktv          = aktv_q[STR_LT];
  assign output_gt_aktv          = aktv_q[STR_GT];
  assign output_neq_aktv         = aktv_q[STR_NEQ];
  assign output_not_a_aktv       = aktv_q[STR_NOT_A];
  assign output_a_impl_b_aktv    = aktv_q[STR_A_IMPL_B];
  assign output_time_stream_aktv = aktv_q[STR_TIME];

endmodule

// File: tb/tb_top_entity.sv
// tb/tb_top_entity.sv - randomized self-checking bench for top_entity
module tb_top_entity;

  localparam int     NS  = 5;
  localparam longint CMP = 5;

  logic clk = 1'b0;
  logic rst, en;
  logic input_a, new_input_a, input_b, new_input_b, new_input_id;
  logic signed [63:0] input_id;

  logic hlc_clock, hlc_a, hlc_b;
  logic signed [63:0] hlc_clock_cnt, hlc_id, llc_stage, output_time_stream;
  logic hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream;
  logic output_lt, output_lt_aktv, output_gt, output_gt_aktv, output_neq, output_neq_aktv;
  logic output_not_a, output_not_a_aktv, output_a_impl_b, output_a_impl_b_aktv;
  logic output_time_stream_aktv;

  top_entity #(.NUM_STAGES(NS), .CMP_CONST(CMP)) dut (
    .clk(clk), .rst(rst), .en(en),
    .input_a(input_a), .new_input_a(new_input_a),
    .input_b(input_b), .new_input_b(new_input_b),
    .input_id(input_id), .new_input_id(new_input_id),
    .hlc_clock(hlc_clock), .hlc_clock_cnt(hlc_clock_cnt),
    .hlc_a(hlc_a), .hlc_b(hlc_b), .hlc_id(hlc_id),
    .hlc_en_lt(hlc_en_lt), .hlc_en_gt(hlc_en_gt), .hlc_en_neq(hlc_en_neq),
    .hlc_en_not_a(hlc_en_not_a), .hlc_en_a_impl_b(hlc_en_a_impl_b),
    .hlc_en_time_stream(hlc_en_time_stream), .llc_stage(llc_stage),
    .output_lt(output_lt), .output_lt_aktv(output_lt_aktv),
    .output_gt(output_gt), .output_gt_aktv(output_gt_aktv),
    .output_neq(output_neq), .output_neq_aktv(output_neq_aktv),
    .output_not_a(output_not_a), .output_not_a_aktv(output_not_a_aktv),
    .output_a_impl_b(output_a_impl_b), .output_a_impl_b_aktv(output_a_impl_b_aktv),
    .output_time_stream(output_time_stream), .output_time_stream_aktv(output_time_stream_aktv)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: counts enabled edges; an event is described by the flags
  // captured at acceptance and its age in enabled edges (1: announced, 2: results shown).
  longint m_cnt, m_id, ev_time, o_time;
  bit     m_a, m_b, ev_a, ev_b, ev_id;
  bit     o_lt, o_gt, o_neq, o_nota, o_impl;
  int     age;

  task automatic model_reset();
    m_cnt = 0; m_id = 0; ev_time = 0; o_time = 0;
    m_a = 0; m_b = 0; ev_a = 0; ev_b = 0; ev_id = 0;
    o_lt = 0; o_gt = 0; o_neq = 0; o_nota = 0; o_impl = 0;
    age = 0;
  endtask

  task automatic model_edge(input bit a, input bit na, input bit b, input bit nb,
                            input longint id, input bit nid);
    if (age == 1) begin
      if (ev_id) begin o_lt = (m_id < CMP); o_gt = (m_id > CMP); end
      if (ev_a && ev_b) begin o_neq = (m_a != m_b); o_impl = (!m_a) || m_b; end
      if (ev_a) o_nota = !m_a;
      o_time = ev_time;
      age = 2;
    end else if (age == 2) begin
      age = 0;
    end
    if ((m_cnt % NS) == 0 && (na || nb || nid)) begin
      if (na)  m_a  = a;
      if (nb)  m_b  = b;
      if (nid) m_id = id;
      ev_a = na; ev_b = nb; ev_id = nid;
      ev_time = m_cnt;
      age = 1;
    end
    m_cnt++;
  endtask

  task automatic compare_all();
    bit ann, sh;
    ann = (age == 1);
    sh  = (age == 2);
    chk("hlc_clock",       hlc_clock,               ann);
    chk("hlc_clock_cnt",   hlc_clock_cnt,           m_cnt);
    chk("llc_stage",       llc_stage,               m_cnt % NS);
    chk("hlc_a",           hlc_a,                   m_a);
    chk("hlc_b",           hlc_b,                   m_b);
    chk("hlc_id",          hlc_id,                  m_id);
    chk("hlc_en_lt",       hlc_en_lt,               ann && ev_id);
    chk("hlc_en_gt",       hlc_en_gt,               ann && ev_id);
    chk("hlc_en_neq",      hlc_en_neq,              ann && ev_a && ev_b);
    chk("hlc_en_not_a",    hlc_en_not_a,            ann && ev_a);
    chk("hlc_en_a_impl_b", hlc_en_a_impl_b,         ann && ev_a && ev_b);
    chk("hlc_en_time",     hlc_en_time_stream,      ann);
    chk("lt",              output_lt,               o_lt);
    chk("gt",              output_gt,               o_gt);
    chk("neq",             output_neq,              o_neq);
    chk("not_a",           output_not_a,            o_nota);
    chk("a_impl_b",        output_a_impl_b,         o_impl);
    chk("time_stream",     output_time_stream,      o_time);
    chk("lt_aktv",         output_lt_aktv,          sh && ev_id);
    chk("gt_aktv",         output_gt_aktv,          sh && ev_id);
    chk("neq_aktv",        output_neq_aktv,         sh && ev_a && ev_b);
    chk("not_a_aktv",      output_not_a_aktv,       sh && ev_a);
    chk("a_impl_b_aktv",   output_a_impl_b_aktv,    sh && ev_a && ev_b);
    chk("time_aktv",       output_time_stream_aktv, sh);
  endtask

  // Drive one cycle of inputs from the falling edge, update the model on the
  // rising edge, check on the next falling edge.
  task automatic step(input bit e, input bit a, input bit na, input bit b, input bit nb,
                      input longint id, input bit nid);
    en = e; input_a = a; new_input_a = na; input_b = b; new_input_b = nb;
    input_id = id; new_input_id = nid;
    @(posedge clk);
    if (e) model_edge(a, na, b, nb, id, nid);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic to_stage(input longint s);
    for (int i = 0; i < NS && (m_cnt % NS) != s; i++) idle(1);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  function automatic longint pick_id();
    case ($urandom_range(0, 6))
      0: return 3;
      1: return -7;
      2: return 9;
      3: return 5;
      4: return 4;
      5: return 6;
      default: return longint'({$urandom, $urandom});
    endcase
  endfunction

  initial begin
    rst = 1'b1; en = 0; input_a = 0; new_input_a = 0; input_b = 0; new_input_b = 0;
    input_id = 0; new_input_id = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // a=b=1 with both flags at stage 0, then its result cycle and the clear cycle
    step(1, 1, 1, 1, 1, 0, 0);
    idle(4);

    // id sweeps across the compare constant
    step(1, 0, 0, 0, 0, 3, 1);  idle(4);
    step(1, 0, 0, 0, 0, -7, 1); idle(4);
    step(1, 0, 0, 0, 0, 9, 1);  idle(4);
    step(1, 0, 0, 0, 0, 5, 1);  idle(4);

    // flag at a non-zero stage is ignored
    to_stage(2);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(3);

    // freeze the pipeline right after acceptance
    to_stage(0);
    step(1, 0, 1, 1, 1, 12, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(5);

    // reset in the middle of an event
    to_stage(0);
    step(1, 1, 1, 0, 1, -1, 1);
    async_reset();
    idle(3);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      else step($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
                1'($urandom), $urandom_range(0, 2) == 0, pick_id(), $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/top_entity.md
TOP_ENTITY -- requirements
Module: top_entity

Interface
REQ-001 Parameter NUM_STAGES, default 5: LLC stages per HLC period; llc_stage counts 0..NUM_STAGES-1.
REQ-002 Parameter CMP_CONST, default 5: signed 64-bit constant used by the lt/gt streams.
REQ-003 clk  in  1  single clock; all state SHALL be on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 en  in  1  global enable; when 0 every register (except under reset) SHALL hold.
REQ-006 input_a / new_input_a  in  1/1  boolean input a and its new-value flag.
REQ-007 input_b / new_input_b  in  1/1  boolean input b and its new-value flag.
REQ-008 input_id / new_input_id  in  64 signed/1  integer input id and its new-value flag.
REQ-009 hlc_clock  out  1  HLC event pulse.
REQ-010 hlc_clock_cnt  out  64 signed  count of enabled clk cycles since reset.
REQ-011 hlc_a, hlc_b, hlc_id  out  1, 1, 64 signed  latched input values.
REQ-012 hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream  out  1 each  per-stream evaluation enables.
REQ-013 llc_stage  out  64 signed  current LLC stage.
REQ-014 output_lt, output_gt, output_neq, output_not_a, output_a_impl_b  out  1 each  stream values; each has a 1-bit *_aktv output.
REQ-015 output_time_stream  out  64 signed  plus output_time_stream_aktv  out  1.

Function
REQ-016 With en=1, llc_stage SHALL increment each cycle and wrap from NUM_STAGES-1 to 0; hlc_clock_cnt SHALL increment by 1 each cycle (wraps at 2^64).
REQ-017 Acceptance edge N: the edge with en=1, llc_stage==0 and at least one new_input_* flag set.
REQ-018 New flags at any other stage SHALL be ignored; inputs and flags are not buffered.
REQ-019 At edge N, hlc_a/hlc_b/hlc_id SHALL load only the inputs whose flag is set; the others SHALL hold.
REQ-020 At edge N, hlc_clock SHALL go to 1 and the hlc_en_* SHALL be registered.
REQ-021 At the next enabled edge, hlc_clock and all hlc_en_* SHALL return to 0.
REQ-022 Stream enables: lt, gt on new_input_id.
REQ-023 Stream enables: neq, a_impl_b on new_input_a AND new_input_b.
REQ-024 Stream enables: not_a on new_input_a; time_stream on any flag.
REQ-025 Stream semantics: lt = hlc_id < CMP_CONST (signed); gt = hlc_id > CMP_CONST (signed).
REQ-026 Stream semantics: neq = hlc_a != hlc_b; not_a = !hlc_a; a_impl_b = !hlc_a | hlc_b.
REQ-027 Stream semantics: time_stream = hlc_clock_cnt value sampled at edge N, pre-increment.
REQ-028 At edge N+1, each enabled stream SHALL register its value and set its *_aktv to 1.
REQ-029 At edge N+2, all *_aktv SHALL clear; output values SHALL hold until the stream is next enabled.
REQ-030 Non-enabled streams SHALL keep their previous value with *_aktv=0.
REQ-031 Minimum event spacing is NUM_STAGES cycles, so pipelines never overlap.
REQ-032 en=0 mid-pipeline SHALL freeze the pipeline; it SHALL resume unchanged when en returns to 1.

Reset
REQ-033 rst=1 SHALL immediately force all outputs, counters, llc_stage and latched values to 0, including mid-event; any pending event is discarded.

Structure
REQ-034 A shared package SHALL hold NUM_STAGES, CMP_CONST, a 64-bit signed integer typedef and the stream-index enumeration.
REQ-035 One sub-module, llc_stage_counter, SHALL generate llc_stage and hlc_clock_cnt; stream evaluation SHALL remain in top_entity.

Verification
REQ-036 Reset: rst=1 mid-run -> all outputs 0 asynchronously; llc_stage=0 after release.
REQ-037 Reset then en=1 at stage 0 with a=1, b=1, new_a=new_b=1 -> edge N: hlc_clock=1, hlc_en_neq/not_a/a_impl_b/time_stream=1, hlc_en_lt/gt=0.
REQ-038 Continuation of REQ-037 -> edge N+1: neq=0, not_a=0, a_impl_b=1, each with aktv=1 for exactly one cycle; lt_aktv=0.
REQ-039 id=3 with new_id=1 at stage 0 -> lt=1, gt=0, both aktv pulse once; id=-7 -> lt=1; id=9 -> gt=1.
REQ-040 new_a=1 asserted at llc_stage=2 -> ignored: no hlc_clock, hlc_a unchanged.
REQ-041 en=0 for 3 cycles after edge N -> llc_stage, hlc_clock_cnt and aktv frozen; aktv pulse appears after en returns to 1; time_stream equals the counter value at edge N.
